// File: rtl/fmc150_rst_sequencer.sv
// Reset/bring-up sequencer for the FMC150 ADC path: MMCM reset, lock wait, IDELAYCTRL reset,
// ADC heartbeat check, then datapath release. Retries on failure and latches a fault when retries run out.
module fmc150_rst_sequencer #(
  parameter int MMCM_RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT      = 1024,
  parameter int IDELAY_RST_CYCLES = 32,
  parameter int HB_WINDOW         = 64,
  parameter int MAX_RETRIES       = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic       clk_sys_i,
  input  logic       rst_i,
  input  logic       mmcm_locked_i,
  input  logic       adc_hb_i,
  input  logic       restart_i,
  output logic       mmcm_rst_o,
  output logic       idelay_rst_o,
  output logic       adc_rst_o,
  output logic       rstn_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt_o
);

  localparam logic [2:0] S_MMCM_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_IDELAY_RST = 3'd2;
  localparam logic [2:0] S_HB_CHECK   = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
  localparam logic [2:0] S_FAULT      = 3'd5;

  localparam logic [CNT_WIDTH-1:0] MMCM_LAST   = CNT_WIDTH'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] IDELAY_LAST = CNT_WIDTH'(IDELAY_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HB_LAST     = CNT_WIDTH'(HB_WINDOW - 1);
  localparam logic [1:0]           RETRY_MAX   = 2'(MAX_RETRIES);

  logic lock_meta, locked_s;
  logic hb_meta, hb_s, hb_d;
  logic hb_edge;

  logic [2:0]           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [1:0]           retry_reg, retry_next;
  logic                 seen_reg, seen_next;
  logic [5:0]           out_reg;

  // Output row: {mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault}
  function automatic logic [5:0] out_row(input logic [2:0] st);
    case (st)
      S_WAIT_LOCK:  out_row = 6'b011000;
      S_IDELAY_RST: out_row = 6'b011000;
      S_HB_CHECK:   out_row = 6'b001000;
      S_RUN:        out_row = 6'b000110;
      S_FAULT:      out_row = 6'b111001;
      default:      out_row = 6'b111000;
    endcase
  endfunction

  assign hb_edge = hb_s ^ hb_d;

  always_comb begin
    logic do_retry;
    logic enter;
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    retry_next = retry_reg;
    seen_next  = seen_reg;
    do_retry   = 1'b0;
    enter      = 1'b0;
    if (restart_i) begin
      state_next = S_MMCM_RST;
      retry_next = 2'd0;
      enter      = 1'b1;
    end else begin
      case (state_reg)
        S_MMCM_RST: begin
          if (cnt_reg == MMCM_LAST) begin
            state_next = S_WAIT_LOCK;
            enter      = 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = S_IDELAY_RST;
            enter      = 1'b1;
          end else if (cnt_reg == LOCK_LAST) begin
            do_retry = 1'b1;
          end
        end
        S_IDELAY_RST: begin
          if (!locked_s) begin
            do_retry = 1'b1;
          end else if (cnt_reg == IDELAY_LAST) begin
            state_next = S_HB_CHECK;
            enter      = 1'b1;
          end
        end
        S_HB_CHECK: begin
          if (!locked_s) begin
            do_retry = 1'b1;
          end else if (hb_edge && seen_reg) begin
            state_next = S_RUN;
            retry_next = 2'd0;
            enter      = 1'b1;
          end else if (cnt_reg == HB_LAST) begin
            do_retry = 1'b1;
          end else if (hb_edge) begin
            seen_next = 1'b1;
          end
        end
        S_RUN: begin
          // An edge landing on the last window cycle still counts as alive.
          if (!locked_s) begin
            do_retry = 1'b1;
          end else if (hb_edge) begin
            cnt_next = '0;
          end else if (cnt_reg == HB_LAST) begin
            do_retry = 1'b1;
          end
        end
        S_FAULT: begin
          cnt_next = cnt_reg;
        end
        default: begin
          state_next = S_MMCM_RST;
          enter      = 1'b1;
        end
      endcase
      if (do_retry) begin
        enter = 1'b1;
        if (retry_reg == RETRY_MAX) begin
          state_next = S_FAULT;
        end else begin
          state_next = S_MMCM_RST;
          retry_next = retry_reg + 1'b1;
        end
      end
    end
    if (enter) begin
      cnt_next  = '0;
      seen_next = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      hb_meta   <= 1'b0;
      hb_s      <= 1'b0;
      hb_d      <= 1'b0;
      state_reg <= S_MMCM_RST;
      cnt_reg   <= '0;
      retry_reg <= 2'd0;
      seen_reg  <= 1'b0;
      out_reg   <= out_row(S_MMCM_RST);
    end else begin
      lock_meta <= mmcm_locked_i;
      locked_s  <= lock_meta;
      hb_meta   <= adc_hb_i;
      hb_s      <= hb_meta;
      hb_d      <= hb_s;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      retry_reg <= retry_next;
      seen_reg  <= seen_next;
      out_reg   <= out_row(state_next);
    end
  end

  assign mmcm_rst_o   = out_reg[5];
  assign idelay_rst_o = out_reg[4];
  assign adc_rst_o    = out_reg[3];
  assign rstn_o       = out_reg[2];
  assign ready_o      = out_reg[1];
  assign fault_o      = out_reg[0];
  assign state_o      = state_reg;
  assign retry_cnt_o  = retry_reg;

endmodule

// File: tb/tb_fmc150_rst_sequencer.sv
// Directed bench for fmc150_rst_sequencer: a phase/countdown model tracks the expected outputs every
// cycle, and literal checks pin dwell lengths, sync latency and the failure timeline.
module tb_fmc150_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       hb = 1'b0;
  logic       restart = 1'b0;
  logic       hb_en = 1'b0;
  logic       mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;

  fmc150_rst_sequencer dut (
    .clk_sys_i(clk), .rst_i(rst), .mmcm_locked_i(lock), .adc_hb_i(hb), .restart_i(restart),
    .mmcm_rst_o(mmcm_rst), .idelay_rst_o(idelay_rst), .adc_rst_o(adc_rst), .rstn_o(rstn),
    .ready_o(ready), .fault_o(fault), .state_o(state), .retry_cnt_o(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Heartbeat source: toggles every 4th cycle while enabled, away from both clock edges.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (hb_en && ph == 0) hb = ~hb;
      ph = (ph + 1) % 4;
    end
  end

  // ---------------- behavioural model ----------------
  int   m_phase, m_left, m_retries, m_edges;
  logic lk_hist[2];
  logic hb_hist[3];

  function automatic logic [5:0] row_of(input int ph);
    case (ph)
      1, 2:    return 6'b011000;
      3:       return 6'b001000;
      4:       return 6'b000110;
      5:       return 6'b111001;
      default: return 6'b111000;
    endcase
  endfunction

  task automatic goto(input int ph);
    m_phase = ph;
    m_edges = 0;
    case (ph)
      0: m_left = 16;
      1: m_left = 1024;
      2: m_left = 32;
      default: m_left = 64;
    endcase
    if (ph == 4) m_retries = 0;
  endtask

  task automatic give_up();
    if (m_retries == 3) goto(5);
    else begin
      m_retries++;
      goto(0);
    end
  endtask

  task automatic model_reset();
    m_retries = 0;
    goto(0);
    lk_hist = '{1'b0, 1'b0};
    hb_hist = '{1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_step(input logic rs, input logic lk_in, input logic hb_in);
    logic locked, hbe;
    locked = lk_hist[1];
    hbe    = hb_hist[1] ^ hb_hist[2];
    if (rs) begin
      m_retries = 0;
      goto(0);
    end else begin
      case (m_phase)
        0: begin m_left--; if (m_left == 0) goto(1); end
        1: if (locked) goto(2); else begin m_left--; if (m_left == 0) give_up(); end
        2: if (!locked) give_up(); else begin m_left--; if (m_left == 0) goto(3); end
        3: if (!locked) give_up();
           else if (hbe && m_edges == 1) goto(4);
           else begin
             if (hbe) m_edges++;
             m_left--;
             if (m_left == 0) give_up();
           end
        4: if (!locked) give_up();
           else if (hbe) m_left = 64;
           else begin m_left--; if (m_left == 0) give_up(); end
        default: ;
      endcase
    end
    lk_hist[1] = lk_hist[0]; lk_hist[0] = lk_in;
    hb_hist[2] = hb_hist[1]; hb_hist[1] = hb_hist[0]; hb_hist[0] = hb_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(restart, lock, hb);
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    check("cycle_outputs",
          {21'd0, mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault, state, retry_cnt},
          {21'd0, row_of(m_phase), 3'(m_phase), 2'(m_retries)});
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] want, input int bound, input string name);
    int n = 0;
    while (state !== want && n < bound) begin
      cycles(1);
      n++;
    end
    check(name, 32'(state), 32'(want));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0] prev;
    logic [1:0] steps[$];

    // Reset values.
    cycles(3);
    check("reset_state", 32'(state), 0);
    check("reset_row", {26'd0, mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault}, 32'b111000);
    check("reset_retry", 32'(retry_cnt), 0);

    // Nominal bring-up: lock after 100 cycles, heartbeat every 4 cycles.
    rst = 1'b0;
    hb_en = 1'b1;
    cycles(15);
    check("mmcm_dwell_15", 32'(mmcm_rst), 1);
    cycles(1);
    check("mmcm_dwell_16", 32'(mmcm_rst), 0);
    check("wait_lock_state", 32'(state), 1);
    cycles(84);
    lock = 1'b1;
    wait_state(3'd2, 200, "reach_idelay");
    n = 0;
    while (state == 3'd2 && n < 100) begin
      cycles(1);
      n++;
    end
    check("idelay_dwell", n, 32);
    wait_state(3'd4, 300, "reach_run");
    check("run_row", {26'd0, mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault}, 32'b000110);
    check("run_retry", 32'(retry_cnt), 0);

    // Lock loss in RUN: effective on the 3rd edge.
    lock = 1'b0;
    cycles(2);
    check("lock_loss_edge2", 32'(state), 4);
    cycles(1);
    check("lock_loss_edge3", {29'd0, state}, 0);
    check("lock_loss_rstn", 32'(rstn), 0);
    check("lock_loss_retry", 32'(retry_cnt), 1);
    lock = 1'b1;
    wait_state(3'd4, 400, "relock_run");
    check("relock_retry_clear", 32'(retry_cnt), 0);

    // Heartbeat stops in RUN.
    hb_en = 1'b0;
    n = 0;
    while (state == 3'd4 && n < 150) begin
      cycles(1);
      n++;
    end
    check("hb_timeout_window", 32'(n >= 60 && n <= 70), 1);
    check("hb_timeout_ready", 32'(ready), 0);
    check("hb_timeout_state", 32'(state), 0);
    hb_en = 1'b1;
    wait_state(3'd4, 300, "hb_resume_run");

    // One lone heartbeat edge inside the window keeps RUN alive.
    hb_en = 1'b0;
    cycles(40);
    hb_en = 1'b1;
    cycles(4);
    hb_en = 1'b0;
    cycles(40);
    check("single_edge_keeps_run", 32'(state), 4);
    hb_en = 1'b1;

    // Asynchronous reset mid HB_CHECK.
    pulse_restart();
    check("restart_from_run", 32'(state), 0);
    wait_state(3'd3, 200, "reach_hb_check");
    #3 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_row", {26'd0, mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault}, 32'b111000);
    @(negedge clk);
    rst = 1'b0;
    wait_state(3'd4, 300, "rerun_after_rst");

    // restart_i coincides with locked_s rising in WAIT_LOCK.
    lock = 1'b0;
    wait_state(3'd1, 200, "reach_wait_lock");
    cycles(5);
    lock = 1'b1;
    cycles(2);
    pulse_restart();
    check("restart_beats_lock", 32'(state), 0);
    check("restart_beats_lock_mmcm", 32'(mmcm_rst), 1);

    // Lock never asserts: full failure timeline.
    lock = 1'b0;
    pulse_restart();
    n = 0;
    prev = retry_cnt;
    while (!fault && n < 5000) begin
      cycles(1);
      n++;
      if (retry_cnt != prev) begin
        steps.push_back(retry_cnt);
        prev = retry_cnt;
      end
    end
    check("fault_latency", n, 4160);
    check("retry_steps", steps.size(), 3);
    for (int i = 0; i < steps.size() && i < 3; i++) check("retry_step_value", 32'(steps[i]), i + 1);
    check("fault_state", 32'(state), 5);
    check("fault_row", {26'd0, mmcm_rst, idelay_rst, adc_rst, rstn, ready, fault}, 32'b111001);
    cycles(20);
    check("fault_absorbing", 32'(state), 5);
    pulse_restart();
    check("fault_restart_state", 32'(state), 0);
    check("fault_restart_fault", 32'(fault), 0);
    check("fault_restart_retry", 32'(retry_cnt), 0);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
